// File: rtl/bit_serial_addsub.sv
// bit_serial_addsub
//   Bit-serial adder/subtractor. Operands are captured on an accepted load,
//   then one bit per clock is processed LSB-first through a single full adder
//   and a carry flop. Result, carry and signed overflow are registered together
//   on the last bit, and done pulses for one cycle.
//
//   Parameters : WIDTH  operand/result width (2..64)
//   Ports      : clk            rising-edge clock
//                rst            asynchronous, active-low reset
//                load           start request, ignored while busy
//                a, b, cy_in    operands and carry-in, sampled on accept only
//                sub            subtract select (SERIAL_SUB_EN builds only)
//                sum, cy_out    result and carry-out / not-borrow
//                ovf            signed overflow
//                busy, done     processing flag and one-cycle completion pulse
//   Build macro: SERIAL_SUB_EN  enables subtraction (B and carry-in inverted);
//                when undefined, sub is accepted but ignored.
//
//   state   | meaning
//   S_IDLE  | waiting for load
//   S_SHIFT | one operand bit per clock
//   S_DONE  | result just written, done high; load here starts next op
module bit_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cy_in,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cy_out,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] TERM_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_out_q, cy_out_d;
  logic             ovf_q, ovf_d;

  logic inv;
  logic s_bit;
  logic c_next;

`ifdef SERIAL_SUB_EN
  assign inv = sub;
`else
  logic sub_unused;
  assign sub_unused = sub;
  assign inv        = 1'b0;
`endif

  assign s_bit  = sa_q[0] ^ sb_q[0] ^ c_q;
  assign c_next = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    sum_d    = sum_q;
    cy_out_d = cy_out_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load) begin
          state_d = S_SHIFT;
          sa_d    = a;
          sb_d    = b ^ {WIDTH{inv}};
          c_d     = cy_in ^ inv;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        sr_d = {s_bit, sr_q[WIDTH-1:1]};
        c_d  = c_next;
        if (cnt_q == TERM_CNT) begin
          // c_q is the carry into the MSB on this last bit.
          state_d  = S_DONE;
          sum_d    = {s_bit, sr_q[WIDTH-1:1]};
          cy_out_d = c_next;
          ovf_d    = c_q ^ c_next;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      sum_q    <= '0;
      cy_out_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      sum_q    <= sum_d;
      cy_out_q <= cy_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sum    = sum_q;
  assign cy_out = cy_out_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_bit_serial_addsub.sv
module tb_bit_serial_addsub;

`ifdef SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] sum;
    logic        cy;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        load8 = 0, cin8 = 0, sub8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [7:0]  sum8;
  logic        cy8, ovf8, busy8, done8;

  logic        load16 = 0, cin16 = 0, sub16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic [15:0] sum16;
  logic        cy16, ovf16, busy16, done16;

  bit_serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst_n), .load(load8), .a(a8), .b(b8), .cy_in(cin8), .sub(sub8),
    .sum(sum8), .cy_out(cy8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  bit_serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst_n), .load(load16), .a(a16), .b(b16), .cy_in(cin16), .sub(sub16),
    .sum(sum16), .cy_out(cy16), .ovf(ovf16), .busy(busy16), .done(done16)
  );

  int errors = 0;
  int checks = 0;
  exp_t q8[$];
  exp_t q16[$];
  int acc8, acc16;
  logic [7:0] last8;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: plain wide addition, overflow from operand/result signs.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sb, input int w);
    exp_t r;
    logic [63:0] mask, bb;
    logic [64:0] full;
    logic cc;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb = b & mask;
    cc = cin;
    if (SUB_EN && sb) begin
      bb = ~b & mask;
      cc = ~cin;
    end
    full  = {1'b0, a & mask} + {1'b0, bb} + {64'd0, cc};
    r.sum = full[63:0] & mask;
    r.cy  = full[w];
    r.ovf = (a[w-1] == bb[w-1]) && (r.sum[w-1] != a[w-1]);
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done8) begin
      if (q8.size() == 0) chk("done8_unexpected", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        chk("sum8", 64'(sum8), e.sum);
        chk("cy8", 64'(cy8), 64'(e.cy));
        chk("ovf8", 64'(ovf8), 64'(e.ovf));
        last8 = e.sum[7:0];
      end
    end
    if (rst_n && done16) begin
      if (q16.size() == 0) chk("done16_unexpected", 64'd1, 64'd0);
      else begin
        e = q16.pop_front();
        chk("sum16", 64'(sum16), e.sum);
        chk("cy16", 64'(cy16), 64'(e.cy));
        chk("ovf16", 64'(ovf16), 64'(e.ovf));
      end
    end
  end

  // Call at a negedge; returns #1 after the accepting edge with load dropped.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sb);
    a8 = a; b8 = b; cin8 = cin; sub8 = sb; load8 = 1'b1;
    q8.push_back(model(64'(a), 64'(b), cin, sb, 8));
    @(posedge clk); #1;
    load8 = 1'b0;
    acc8 = cyc;
    a8 = $urandom; b8 = $urandom; cin8 = $urandom; sub8 = $urandom;
  endtask

  // Returns at the negedge where done is high (or after the budget expires).
  task automatic wait_done8();
    int n;
    n = 0;
    @(negedge clk);
    chk("busy8_after_accept", 64'(busy8), 64'd1);
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done8) chk("timeout8", 64'd0, 64'd1);
    else begin
      chk("lat8", 64'(cyc - acc8), 64'd8);
      chk("busy8_in_done", 64'(busy8), 64'd0);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sb);
    start8(a, b, cin, sb);
    wait_done8();
  endtask

  initial begin
    #2;
    chk("rst_sum8", 64'(sum8), 64'd0);
    chk("rst_cy8", 64'(cy8), 64'd0);
    chk("rst_ovf8", 64'(ovf8), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run8(8'hAA, 8'h5D, 1'b0, 1'b0);
    @(negedge clk);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_done8", 64'(done8), 64'd0);
    run8(8'h05, 8'h07, 1'b0, 1'b1);
    @(negedge clk);

    // Load during busy is dropped; sum holds the previous result meanwhile.
    start8(8'hBA, 8'hDD, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold8", 64'(sum8), 64'(last8));
    a8 = 8'h11; b8 = 8'h22; load8 = 1'b1;
    @(posedge clk); #1;
    load8 = 1'b0;
    begin
      int n;
      n = 0;
      while (!done8 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!done8) chk("timeout8_ign", 64'd0, 64'd1);
      else chk("lat8_ign", 64'(cyc - acc8), 64'd8);
    end
    // Load in the DONE cycle is accepted back-to-back.
    run8(8'h3C, 8'h0F, 1'b1, 1'b0);

    // Reset in the middle of an op.
    @(negedge clk);
    start8(8'hF0, 8'h0F, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy8", 64'(busy8), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum8", 64'(sum8), 64'd0);
    chk("mid_rst_cy8", 64'(cy8), 64'd0);
    chk("mid_rst_ovf8", 64'(ovf8), 64'd0);
    chk("mid_rst_busy8", 64'(busy8), 64'd0);
    chk("mid_rst_done8", 64'(done8), 64'd0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run8(8'h01, 8'h01, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    run8(8'h80, 8'h80, 1'b0, 1'b0);
    @(negedge clk);
    run8(8'h00, 8'h00, 1'b1, 1'b1);
    @(negedge clk);

    // 16-bit instance.
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b1; sub16 = 1'b0; load16 = 1'b1;
    q16.push_back(model(64'h0000_0000_0000_FFFF, 64'd1, 1'b1, 1'b0, 16));
    @(posedge clk); #1;
    load16 = 1'b0;
    acc16 = cyc;
    begin
      int n;
      n = 0;
      while (!done16 && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (!done16) chk("timeout16", 64'd0, 64'd1);
      else chk("lat16", 64'(cyc - acc16), 64'd16);
    end
    repeat (3) @(negedge clk);

    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q16_drained", 64'(q16.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
